// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Package  : riscv_defines
// Purpose  : Shared constants for the memory controller: reset polarity,
//            boolean aliases, FSM state encoding, data_len encodings and the
//            default IO region tag.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_defines;

  localparam logic RstEnable = 1'b1;
  localparam logic True      = 1'b1;
  localparam logic False     = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } mem_state_e;

  // Loads encode the byte count directly, stores encode count minus one.
  localparam logic [2:0] LEN_LD_BYTE = 3'd1;
  localparam logic [2:0] LEN_LD_HALF = 3'd2;
  localparam logic [2:0] LEN_LD_WORD = 3'd4;
  localparam logic [2:0] LEN_ST_BYTE = 3'd0;
  localparam logic [2:0] LEN_ST_HALF = 3'd1;
  localparam logic [2:0] LEN_ST_WORD = 3'd3;

  localparam logic [1:0] IO_BASE_DEFAULT = 2'b11;

  // Map either data_len flavour onto a byte count of 1, 2 or 4.
  function automatic logic [2:0] norm_len(input logic is_store, input logic [2:0] len);
    logic [2:0] n;
    n = 3'd1;
    if (is_store) begin
      case (len)
        LEN_ST_BYTE: n = 3'd1;
        LEN_ST_HALF: n = 3'd2;
        LEN_ST_WORD: n = 3'd4;
        default:     n = 3'd1;
      endcase
    end else begin
      case (len)
        LEN_LD_BYTE: n = 3'd1;
        LEN_LD_HALF: n = 3'd2;
        LEN_LD_WORD: n = 3'd4;
        default:     n = 3'd1;
      endcase
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Sole master of the byte-wide RAM/IO bus. Serialises 1/2/4-byte
//            data loads/stores and 4-byte instruction fetches into byte
//            accesses, data port has priority over fetch.
// Options  : MEMCTRL_IO_STALL_EN - hold IO-region stores in IDLE while the
//            IO write buffer reports full.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
  import riscv_defines::*;
#(
  parameter int         ADDR_W  = 32,
  parameter logic [1:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_read,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic [2:0]        data_len,
  output logic              mem_load_done,
  output logic [31:0]       mem_ctrl_read_in,
  output logic [1:0]        mem_ctrl_busy_state,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_a_q, ram_a_d;
  logic [2:0]        len_q, len_d, cnt_q, cnt_d, rcv_q, rcv_d;
  logic              rd_q, rd_d, pend_q, pend_d, fetch_q, fetch_d;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d, mem_rd_q, mem_rd_d;
  logic [1:0]        busy;

  logic              data_req, data_go, fetch_go, io_stall;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_byte;
  logic [31:0]       buf_ins;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = write_mem & (mem_addr[17:16] == IO_BASE) & io_buffer_full;
`else
  // IO stores are treated as ordinary stores; the buffer-full flag has no effect.
  assign io_stall = False & io_buffer_full & (mem_addr[17:16] == IO_BASE);
`endif

  assign data_req  = read_mem | write_mem;
  assign data_go   = data_req & ~io_stall;
  assign fetch_go  = if_read & ~data_req;
  assign next_addr = addr_q + ADDR_W'(cnt_q);
  assign next_byte = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
  assign buf_ins   = buf_q | (32'(ram_din) << {rcv_q[1:0], 3'b000});

  // Next-state logic: accept, issue byte addresses, collect read bytes, pulse done.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rcv_d      = rcv_q;
    rd_d       = rd_q;
    pend_d     = pend_q;
    fetch_d    = fetch_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;
    if_done_d  = False;
    mem_done_d = False;
    if_data_d  = if_data_q;
    mem_rd_d   = mem_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (data_go) begin
          addr_d  = mem_addr;
          len_d   = norm_len(write_mem, data_len);
          wdata_d = mem_data;
          buf_d   = '0;
          ram_a_d = mem_addr;
          cnt_d   = 3'd1;
          rcv_d   = 3'd0;
          pend_d  = False;
          fetch_d = False;
          if (write_mem) begin
            state_d    = ST_STORE;
            ram_wr_d   = True;
            ram_dout_d = mem_data[7:0];
            rd_d       = False;
          end else begin
            state_d = ST_LOAD;
            rd_d    = True;
          end
        end else if (fetch_go) begin
          state_d = ST_FETCH;
          addr_d  = if_addr;
          len_d   = 3'd4;
          buf_d   = '0;
          ram_a_d = if_addr;
          cnt_d   = 3'd1;
          rcv_d   = 3'd0;
          rd_d    = True;
          pend_d  = False;
          fetch_d = True;
        end
      end
      ST_LOAD, ST_FETCH: begin
        // The byte addressed last cycle is on ram_din now.
        pend_d = rd_q;
        if (cnt_q < len_q) begin
          ram_a_d = next_addr;
          cnt_d   = cnt_q + 3'd1;
          rd_d    = True;
        end else begin
          ram_a_d = '0;
          rd_d    = False;
        end
        if (pend_q) begin
          buf_d = buf_ins;
          rcv_d = rcv_q + 3'd1;
          if (rcv_q == 3'(len_q - 3'd1)) begin
            state_d = ST_DONE;
            if (fetch_q) begin
              if_done_d = True;
              if_data_d = buf_ins;
            end else begin
              mem_done_d = True;
              mem_rd_d   = buf_ins;
            end
          end
        end
      end
      ST_STORE: begin
        if (cnt_q < len_q) begin
          ram_a_d    = next_addr;
          ram_dout_d = next_byte;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          ram_a_d    = '0;
          ram_dout_d = 8'h00;
          ram_wr_d   = False;
          mem_done_d = True;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Busy flags: in IDLE they reflect the request being accepted (or IO-stalled) this cycle.
  always_comb begin
    busy = 2'b00;
    case (state_q)
      ST_IDLE:           if (rdy_in && !rst_in) busy = {fetch_go, data_req};
      ST_FETCH:          busy = 2'b10;
      ST_LOAD, ST_STORE: busy = 2'b01;
      ST_DONE:           busy = fetch_q ? 2'b10 : 2'b01;
      default:           busy = 2'b00;
    endcase
  end

  // State registers; rdy_in low freezes everything (the RAM read register freezes with us).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RstEnable) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= 3'd0;
      cnt_q      <= 3'd0;
      rcv_q      <= 3'd0;
      rd_q       <= 1'b0;
      pend_q     <= 1'b0;
      fetch_q    <= 1'b0;
      wdata_q    <= '0;
      buf_q      <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= 8'h00;
      ram_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_data_q  <= '0;
      mem_rd_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rcv_q      <= rcv_d;
      rd_q       <= rd_d;
      pend_q     <= pend_d;
      fetch_q    <= fetch_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if_data_q  <= if_data_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign ram_a               = ram_a_q;
  assign ram_dout            = ram_dout_q;
  assign ram_wr              = ram_wr_q & rdy_in;
  assign if_done             = if_done_q;
  assign if_data             = if_data_q;
  assign mem_load_done       = mem_done_q;
  assign mem_ctrl_read_in    = mem_rd_q;
  assign mem_ctrl_busy_state = busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a byte RAM model
//            (1-cycle read latency, frozen together with the core on rdy_in).
// Options  : MEMCTRL_IO_STALL_EN selects the IO-stall timing expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

`ifdef MEMCTRL_IO_STALL_EN
  localparam int STALL = 5;
`else
  localparam int STALL = 0;
`endif

  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic        if_read = 1'b0, read_mem = 1'b0, write_mem = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_data = '0;
  logic [2:0]  data_len = '0;
  logic [7:0]  ram_din = 8'h00;
  logic        if_done, mem_load_done, ram_wr;
  logic [31:0] if_data, mem_ctrl_read_in, ram_a;
  logic [1:0]  mem_ctrl_busy_state;
  logic [7:0]  ram_dout;

  int n_checks = 0, n_errors = 0;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_read(if_read), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .read_mem(read_mem), .write_mem(write_mem), .mem_addr(mem_addr),
    .mem_data(mem_data), .data_len(data_len), .mem_load_done(mem_load_done),
    .mem_ctrl_read_in(mem_ctrl_read_in), .mem_ctrl_busy_state(mem_ctrl_busy_state),
    .io_buffer_full(io_buffer_full), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk_in = ~clk_in;

  // RAM model with a bench preload port
  logic [7:0] ram [0:1023];
  logic       pl_en = 1'b0;
  logic [9:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  always @(posedge clk_in) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (rdy_in) begin
      if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
      ram_din <= ram[ram_a[9:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(posedge clk_in); #1;
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk_in); #1;
    pl_en = 1'b0;
  endtask

  logic [31:0] a_log [0:19];
  logic        wr_log [0:19];
  logic [7:0]  dout_log [0:19];
  logic [1:0]  busy_log [0:19];
  int          md_cnt, md_cyc, id_cnt, id_cyc;
  logic [31:0] md_data, id_data;

  // Cycle 0 is the cycle in which the caller raised the request.
  task automatic watch(input int ncyc, input int drop_mem_at, input int drop_if_at,
                       input int frz_start, input int frz_len, input int io_full_until);
    md_cnt = 0; id_cnt = 0; md_cyc = -1; id_cyc = -1; md_data = '0; id_data = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_in);
      a_log[c] = ram_a; wr_log[c] = ram_wr; dout_log[c] = ram_dout;
      busy_log[c] = mem_ctrl_busy_state;
      if (mem_load_done) begin
        md_cnt++;
        if (md_cyc < 0) begin md_cyc = c; md_data = mem_ctrl_read_in; end
      end
      if (if_done) begin
        id_cnt++;
        if (id_cyc < 0) begin id_cyc = c; id_data = if_data; end
      end
      @(posedge clk_in); #1;
      if (c >= drop_mem_at) begin read_mem = 1'b0; write_mem = 1'b0; end
      if (c >= drop_if_at) if_read = 1'b0;
      rdy_in = !((c + 1) >= frz_start && (c + 1) < frz_start + frz_len);
      io_buffer_full = ((c + 1) < io_full_until);
    end
  endtask

  initial begin
    int wr_cnt;
    // Reset and idle
    repeat (3) begin
      @(negedge clk_in);
      check("rst_ram_a", ram_a, 32'h0);
      check("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
      check("rst_busy", {30'b0, mem_ctrl_busy_state}, 32'h0);
      check("rst_dones", {30'b0, if_done, mem_load_done}, 32'h0);
      check("rst_data", mem_ctrl_read_in | if_data | {24'b0, ram_dout}, 32'h0);
    end
    @(posedge clk_in); #1 rst_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check("idle_ram_wr", {31'b0, ram_wr}, 32'h0);
      check("idle_busy", {30'b0, mem_ctrl_busy_state}, 32'h0);
      check("idle_ram_a", ram_a, 32'h0);
    end

    // Preload RAM
    poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
    poke(10'h200, 8'hCD); poke(10'h201, 8'hAB);
    poke(10'h300, 8'hEF); poke(10'h301, 8'hBE); poke(10'h302, 8'hAD); poke(10'h303, 8'hDE);
    poke(10'h021, 8'h5A); poke(10'h041, 8'h00);

    // LW at 0x100
    @(posedge clk_in); #1;
    read_mem = 1'b1; mem_addr = 32'h100; data_len = 3'd4;
    watch(9, 0, 0, 100, 0, 0);
    for (int c = 1; c <= 4; c++) check("lw_ram_a", a_log[c], 32'h100 + 32'(c - 1));
    check("lw_ram_a_idle", a_log[5], 32'h0);
    check("lw_done_cyc", md_cyc, 6);
    check("lw_done_cnt", md_cnt, 1);
    check("lw_data", md_data, 32'h12345678);
    check("lw_busy_accept", {30'b0, busy_log[0]}, 32'h1);
    check("lw_busy_done", {30'b0, busy_log[6]}, 32'h1);
    check("lw_busy_after", {30'b0, busy_log[7]}, 32'h0);
    wr_cnt = 0;
    for (int c = 0; c < 9; c++) wr_cnt += int'(wr_log[c]);
    check("lw_no_wr", wr_cnt, 0);

    // SB 0xAB to 0x20
    @(posedge clk_in); #1;
    write_mem = 1'b1; mem_addr = 32'h20; mem_data = 32'h0000_00AB; data_len = 3'd0;
    watch(6, 0, 0, 100, 0, 0);
    wr_cnt = 0;
    for (int c = 0; c < 6; c++) wr_cnt += int'(wr_log[c]);
    check("sb_wr_cnt", wr_cnt, 1);
    check("sb_wr_cyc1", {31'b0, wr_log[1]}, 32'h1);
    check("sb_ram_a", a_log[1], 32'h20);
    check("sb_dout", {24'b0, dout_log[1]}, 32'hAB);
    check("sb_done_cyc", md_cyc, 2);
    check("sb_mem20", {24'b0, ram[10'h020]}, 32'hAB);
    check("sb_mem21", {24'b0, ram[10'h021]}, 32'h5A);

    // LH and fetch together: data first, then fetch
    @(posedge clk_in); #1;
    read_mem = 1'b1; mem_addr = 32'h200; data_len = 3'd2;
    if_read = 1'b1; if_addr = 32'h300;
    watch(14, 0, 5, 100, 0, 0);
    check("arb_lh_cnt", md_cnt, 1);
    check("arb_lh_cyc", md_cyc, 4);
    check("arb_lh_data", md_data, 32'h0000ABCD);
    check("arb_if_cnt", id_cnt, 1);
    check("arb_if_cyc", id_cyc, 11);
    check("arb_if_data", id_data, 32'hDEADBEEF);
    check("arb_busy0", {30'b0, busy_log[0]}, 32'h1);
    check("arb_busy4", {30'b0, busy_log[4]}, 32'h1);
    check("arb_busy5", {30'b0, busy_log[5]}, 32'h2);
    check("arb_busy11", {30'b0, busy_log[11]}, 32'h2);
    check("arb_busy12", {30'b0, busy_log[12]}, 32'h0);
    check("arb_a1", a_log[1], 32'h200);
    check("arb_a6", a_log[6], 32'h300);
    check("arb_a9", a_log[9], 32'h303);

    // LW with rdy_in low for cycles 3..5
    @(posedge clk_in); #1;
    read_mem = 1'b1; mem_addr = 32'h100; data_len = 3'd4;
    watch(12, 0, 0, 3, 3, 0);
    check("frz_done_cyc", md_cyc, 9);
    check("frz_done_cnt", md_cnt, 1);
    check("frz_data", md_data, 32'h12345678);
    check("frz_a2", a_log[2], 32'h101);
    check("frz_a5_hold", a_log[5], 32'h102);
    check("frz_a6_hold", a_log[6], 32'h102);
    check("frz_a7", a_log[7], 32'h103);
    check("frz_busy4", {30'b0, busy_log[4]}, 32'h1);

    // Reset in the middle of a store
    @(posedge clk_in); #1;
    write_mem = 1'b1; mem_addr = 32'h40; mem_data = 32'h11223344; data_len = 3'd3;
    @(negedge clk_in);
    @(posedge clk_in); #1 write_mem = 1'b0;
    @(negedge clk_in);
    check("rst_st_wr1", {31'b0, ram_wr}, 32'h1);
    check("rst_st_a1", ram_a, 32'h40);
    @(posedge clk_in); #1 rst_in = 1'b1;
    #1;
    check("rst_st_wr", {31'b0, ram_wr}, 32'h0);
    check("rst_st_a", ram_a, 32'h0);
    check("rst_st_busy", {30'b0, mem_ctrl_busy_state}, 32'h0);
    repeat (2) begin
      @(negedge clk_in);
      check("rst_st_done", {31'b0, mem_load_done}, 32'h0);
    end
    @(posedge clk_in); #1 rst_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check("rst_st_idle_done", {31'b0, mem_load_done}, 32'h0);
      check("rst_st_idle_wr", {31'b0, ram_wr}, 32'h0);
    end
    check("rst_st_mem40", {24'b0, ram[10'h040]}, 32'h44);
    check("rst_st_mem41", {24'b0, ram[10'h041]}, 32'h00);

    // SW to IO region 0x30000 with io_buffer_full high for 5 cycles
    @(posedge clk_in); #1;
    write_mem = 1'b1; mem_addr = 32'h0003_0000; mem_data = 32'hCAFEF00D; data_len = 3'd3;
    io_buffer_full = 1'b1;
    watch(STALL + 8, STALL, 0, 100, 0, 5);
    wr_cnt = 0;
    for (int c = 0; c <= STALL; c++) wr_cnt += int'(wr_log[c]);
    check("io_no_wr_stall", wr_cnt, 0);
    wr_cnt = 0;
    for (int c = 0; c < STALL + 8; c++) wr_cnt += int'(wr_log[c]);
    check("io_wr_cnt", wr_cnt, 4);
    check("io_a_first", a_log[STALL + 1], 32'h0003_0000);
    check("io_a_last", a_log[STALL + 4], 32'h0003_0003);
    check("io_dout_first", {24'b0, dout_log[STALL + 1]}, 32'h0D);
    check("io_dout_last", {24'b0, dout_log[STALL + 4]}, 32'hCA);
    check("io_done_cyc", md_cyc, STALL + 5);
    check("io_busy0", {30'b0, busy_log[0]}, 32'h1);
    check("io_mem3", {24'b0, ram[10'h003]}, 32'hCA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
